// File: rtl/dpbram_pkg.sv
// Shared definitions for the dual-port block RAM: write modes, clear FSM states
// and the per-byte even-parity helper.
package dpbram_pkg;

   localparam int WM_NO_CHANGE  = 0;
   localparam int WM_READ_FIRST = 1;

   // Parity helper is sized for the widest supported word; callers zero-extend.
   localparam int PAR_MAXW  = 256;
   localparam int PAR_MAXNB = PAR_MAXW / 8;

   typedef enum logic {
      ST_CLEAR,
      ST_RUN
   } state_t;

   function automatic logic [PAR_MAXNB-1:0] byte_parity(input logic [PAR_MAXW-1:0] data);
      logic [PAR_MAXNB-1:0] p;
      for (int i = 0; i < PAR_MAXNB; i++) begin
         p[i] = ^data[i*8 +: 8];
      end
      return p;
   endfunction

endpackage

// File: rtl/dpbram_rd_pipe.sv
// Read-data delay line placed after the RAM output register; STAGES extra cycles
// of {data, valid, parity-error}. Data only advances with its valid so it holds.
module dpbram_rd_pipe #(
   parameter int W      = 32,
   parameter int STAGES = 0
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic [W-1:0] dat_i,
   input  logic         vld_i,
   input  logic         perr_i,
   output logic [W-1:0] dat_o,
   output logic         vld_o,
   output logic         perr_o
);

   if (STAGES == 0) begin : g_bypass
      logic unused_bypass;
      assign unused_bypass = ^{clk_i, rst_n_i};
      assign dat_o  = dat_i;
      assign vld_o  = vld_i;
      assign perr_o = perr_i;
   end else begin : g_pipe
      logic [W-1:0]      dat_q [STAGES];
      logic [STAGES-1:0] vld_q;
      logic [STAGES-1:0] perr_q;

      always_ff @(posedge clk_i) begin
         if (!rst_n_i) begin
            vld_q  <= '0;
            perr_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
               dat_q[i] <= '0;
            end
         end else begin
            vld_q[0]  <= vld_i;
            perr_q[0] <= perr_i;
            if (vld_i) begin
               dat_q[0] <= dat_i;
            end
            for (int i = 1; i < STAGES; i++) begin
               vld_q[i]  <= vld_q[i-1];
               perr_q[i] <= perr_q[i-1];
               if (vld_q[i-1]) begin
                  dat_q[i] <= dat_q[i-1];
               end
            end
         end
      end

      assign dat_o  = dat_q[STAGES-1];
      assign vld_o  = vld_q[STAGES-1];
      assign perr_o = perr_q[STAGES-1];
   end

endmodule

// File: rtl/dpbram_sc_pipe.sv
// Single-clock true-dual-port RAM with byte enables, pipelined reads, power-up clear
// sweep and collision flag. Define DPBRAM_PARITY_EN to store/check per-byte parity.
module dpbram_sc_pipe
   import dpbram_pkg::*;
#(
   parameter  int DWIDTH       = 32,
   parameter  int RAM_DEPTH    = 1024,
   parameter  int READ_LATENCY = 1,
   parameter  int WRITE_MODE   = WM_NO_CHANGE,
   parameter  int CLEAR_ON_RST = 1,
   localparam int NB           = DWIDTH / 8,
   localparam int AW           = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [AW-1:0]     s_addr,
   input  logic              s_ce,
   input  logic [NB-1:0]     s_we,
   input  logic [DWIDTH-1:0] s_din,
   output logic [DWIDTH-1:0] s_dout,
   output logic              s_dv,
   output logic              s_perr,
   input  logic [AW-1:0]     m_addr,
   input  logic              m_ce,
   input  logic [NB-1:0]     m_we,
   input  logic [DWIDTH-1:0] m_din,
   output logic [DWIDTH-1:0] m_dout,
   output logic              m_dv,
   output logic              m_perr,
   output logic              o_busy,
   output logic              o_coll
);

`ifdef DPBRAM_PARITY_EN
   localparam int PB = NB;
`else
   localparam int PB = 0;
`endif
   localparam int MW = DWIDTH + PB;

   (* ram_style = "block" *) logic [MW-1:0] mem [RAM_DEPTH];

   state_t          state_q, state_d;
   logic [AW-1:0]   clr_addr_q, clr_addr_d;
   logic            clr_wr, run;
   logic            s_acc, m_acc, s_inr, m_inr, s_rv_d, m_rv_d, coll_d;
   logic [NB-1:0]   s_wl, m_wl;
   logic [MW-1:0]   s_rdat_q, m_rdat_q;
   logic            s_rv_q, m_rv_q, coll_q;
   logic            s_perr_c, m_perr_c;

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      clr_wr     = 1'b0;
      if (state_q == ST_CLEAR) begin
         clr_wr     = i_rst;
         clr_addr_d = clr_addr_q + 1'b1;
         if (clr_addr_q == AW'(RAM_DEPTH - 1)) begin
            state_d    = ST_RUN;
            clr_addr_d = '0;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q    <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_RUN;
         clr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   assign o_busy = i_rst & (state_q == ST_CLEAR);
   assign run    = i_rst & (state_q == ST_RUN);
   assign s_acc  = s_ce & run;
   assign m_acc  = m_ce & run;
   assign s_inr  = int'(s_addr) < RAM_DEPTH;
   assign m_inr  = int'(m_addr) < RAM_DEPTH;
   assign s_wl   = {NB{s_acc & s_inr}} & s_we;
   assign m_wl   = {NB{m_acc & m_inr}} & m_we;
   assign s_rv_d = s_acc & ((s_we == '0) | (WRITE_MODE == WM_READ_FIRST));
   assign m_rv_d = m_acc & ((m_we == '0) | (WRITE_MODE == WM_READ_FIRST));
   assign coll_d = s_acc & m_acc & s_inr & (s_addr == m_addr) & ((|s_we) | (|m_we));

   // M lanes are written first so S overrides them on shared lanes of a collision.
   always_ff @(posedge i_clk) begin
      if (clr_wr) begin
         mem[clr_addr_q] <= '0;
      end else begin
         for (int i = 0; i < NB; i++) begin
            if (m_wl[i]) begin
               mem[m_addr][i*8 +: 8] <= m_din[i*8 +: 8];
`ifdef DPBRAM_PARITY_EN
               mem[m_addr][DWIDTH+i] <= ^m_din[i*8 +: 8];
`endif
            end
         end
         for (int i = 0; i < NB; i++) begin
            if (s_wl[i]) begin
               mem[s_addr][i*8 +: 8] <= s_din[i*8 +: 8];
`ifdef DPBRAM_PARITY_EN
               mem[s_addr][DWIDTH+i] <= ^s_din[i*8 +: 8];
`endif
            end
         end
      end
   end

   // RAM output register: always sees the pre-write word, giving read-first collisions.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         s_rv_q   <= 1'b0;
         m_rv_q   <= 1'b0;
         coll_q   <= 1'b0;
         s_rdat_q <= '0;
         m_rdat_q <= '0;
      end else begin
         s_rv_q <= s_rv_d;
         m_rv_q <= m_rv_d;
         coll_q <= coll_d;
         if (s_rv_d) begin
            s_rdat_q <= s_inr ? mem[s_addr] : '0;
         end
         if (m_rv_d) begin
            m_rdat_q <= m_inr ? mem[m_addr] : '0;
         end
      end
   end

`ifdef DPBRAM_PARITY_EN
   assign s_perr_c = s_rv_q & (|(byte_parity(PAR_MAXW'(s_rdat_q[DWIDTH-1:0]))
                                 ^ PAR_MAXNB'(s_rdat_q[MW-1:DWIDTH])));
   assign m_perr_c = m_rv_q & (|(byte_parity(PAR_MAXW'(m_rdat_q[DWIDTH-1:0]))
                                 ^ PAR_MAXNB'(m_rdat_q[MW-1:DWIDTH])));
`else
   assign s_perr_c = 1'b0;
   assign m_perr_c = 1'b0;
`endif

   assign o_coll = coll_q;

   dpbram_rd_pipe #(.W(DWIDTH), .STAGES(READ_LATENCY - 1)) u_s_pipe (
      .clk_i   (i_clk),
      .rst_n_i (i_rst),
      .dat_i   (s_rdat_q[DWIDTH-1:0]),
      .vld_i   (s_rv_q),
      .perr_i  (s_perr_c),
      .dat_o   (s_dout),
      .vld_o   (s_dv),
      .perr_o  (s_perr)
   );

   dpbram_rd_pipe #(.W(DWIDTH), .STAGES(READ_LATENCY - 1)) u_m_pipe (
      .clk_i   (i_clk),
      .rst_n_i (i_rst),
      .dat_i   (m_rdat_q[DWIDTH-1:0]),
      .vld_i   (m_rv_q),
      .perr_i  (m_perr_c),
      .dat_o   (m_dout),
      .vld_o   (m_dv),
      .perr_o  (m_perr)
   );

endmodule
